// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout and sticky trap.
// Optional performance counters are enabled by defining MC_PERF_COUNTERS_EN.
module mc_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             branch,
  output logic             branch_ne,
  output logic             regDst,
  output logic             memRead,
  output logic             memWrite,
  output logic [2:0]       ALUop,
  output logic             ALUsrc,
  output logic             regWrite,
  output logic             link,
  output logic             byteOperations,
  output logic             move,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state
`ifdef MC_PERF_COUNTERS_EN
  ,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
`endif
);

  if (CNT_W == 0 || TO_W == 0 || 64'(MEM_TIMEOUT) >= (64'd1 << TO_W)) begin : g_bad_params
    $error("mc_control_unit: TO_W too narrow for MEM_TIMEOUT, or zero-width counter");
  end

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_SUBI = 6'b000011;
  localparam logic [5:0] OP_ANDI = 6'b000100;
  localparam logic [5:0] OP_ORI  = 6'b000101;
  localparam logic [5:0] OP_SLTI = 6'b000111;
  localparam logic [5:0] OP_LW   = 6'b001000;
  localparam logic [5:0] OP_LB   = 6'b001001;
  localparam logic [5:0] OP_SW   = 6'b010000;
  localparam logic [5:0] OP_SB   = 6'b010001;
  localparam logic [5:0] OP_MOVE = 6'b100000;
  localparam logic [5:0] OP_BEQ  = 6'b100011;
  localparam logic [5:0] OP_BNE  = 6'b100111;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JAL  = 6'b111001;

  localparam bit            TO_EN    = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'((MEM_TIMEOUT == 0) ? 32'd0 : MEM_TIMEOUT - 32'd1);

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_R, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI,
      OP_LW, OP_LB, OP_SW, OP_SB,
      OP_MOVE, OP_BEQ, OP_BNE, OP_J, OP_JAL: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_op_of(input logic [5:0] op);
    case (op)
      OP_R:                              return 3'b111;
      OP_ADDI, OP_LW, OP_LB, OP_SW, OP_SB: return 3'b101;
      OP_SUBI, OP_BEQ, OP_BNE:           return 3'b110;
      OP_SLTI:                           return 3'b100;
      OP_ORI:                            return 3'b001;
      default:                           return 3'b000;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [5:0]      op_q;
  logic [TO_W-1:0] wait_q;
  logic [1:0]      cause_q, cause_d;
  logic            wait_en, timeout_hit;
  logic            is_load, is_store, is_byte, is_branch, is_imm_src;

  assign is_load    = (op_q == OP_LW) || (op_q == OP_LB);
  assign is_store   = (op_q == OP_SW) || (op_q == OP_SB);
  assign is_byte    = (op_q == OP_LB) || (op_q == OP_SB);
  assign is_branch  = (op_q == OP_BEQ) || (op_q == OP_BNE);
  assign is_imm_src = is_load || is_store || (op_q == OP_ADDI) || (op_q == OP_SUBI) ||
                      (op_q == OP_ANDI) || (op_q == OP_ORI) || (op_q == OP_SLTI);

  assign wait_en     = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
  assign timeout_hit = TO_EN && wait_en && (wait_q == TO_LIMIT);

  assign state      = state_q;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      // IR is written at the end of FETCH, so the opcode is captured while leaving DECODE
      if (state_q == S_DECODE) op_q <= opcode;
      if (state_d != state_q)  wait_q <= '0;
      else if (wait_en)        wait_q <= wait_q + TO_W'(1);
      if (state_d == S_TRAP && state_q != S_TRAP) cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cause_d        = 2'b00;
    mem_req        = 1'b0;
    i_or_d         = 1'b0;
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    pc_src         = 2'b00;
    branch         = 1'b0;
    branch_ne      = 1'b0;
    regDst         = 1'b0;
    memRead        = 1'b0;
    memWrite       = 1'b0;
    ALUop          = 3'b000;
    ALUsrc         = 1'b0;
    regWrite       = 1'b0;
    link           = 1'b0;
    byteOperations = 1'b0;
    move           = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        memRead = 1'b1;
        ALUop   = 3'b101;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        if (!op_legal(opcode)) begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end else if (opcode == OP_J || opcode == OP_JAL) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          regWrite = (opcode == OP_JAL);
          link     = (opcode == OP_JAL);
          state_d  = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        ALUop  = alu_op_of(op_q);
        ALUsrc = is_imm_src;
        if (is_branch) begin
          branch    = 1'b1;
          pc_src    = 2'b01;
          branch_ne = (op_q == OP_BNE);
          state_d   = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req        = 1'b1;
        i_or_d         = 1'b1;
        memRead        = is_load;
        memWrite       = is_store;
        byteOperations = is_byte;
        if (mem_ready) begin
          state_d = is_load ? S_WB : S_FETCH;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_WB: begin
        regWrite = 1'b1;
        regDst   = (op_q == OP_R);
        memRead  = is_load;
        move     = (op_q == OP_MOVE);
        state_d  = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

`ifdef MC_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else if (state_q != S_TRAP) begin
      cycle_count <= cycle_count + CNT_W'(1);
      if (state_d == S_FETCH && state_q != S_FETCH) instr_count <= instr_count + CNT_W'(1);
    end
  end
`endif

endmodule
